// File: rtl/alu_arbiter_pkg.sv
// Shared types for alu_arbiter: ALU opcodes and the arbiter FSM states.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_INV = 2'd2,
    OP_CMP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_add_sub_logic.sv
// Combinational ALU shared by both arbiter requesters; add/sub wrap modulo 2^WIDTH.
module add_sub_logic
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_INV:  r = ~b;
      OP_CMP:  r[0] = (b < a);
      default: r = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_r,
  output logic             rsp_id,
  output logic             busy
);

  state_e           state, state_nxt;
  logic             armed;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] alu_r;
  logic             grant;
  logic             accept;
`ifdef ALU_ARBITER_RR_EN
  logic             last_grant;
`endif

  add_sub_logic #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .r  (alu_r)
  );

  // Lone requester always wins; a tie goes to the policy selected at build time.
  always_comb begin
    grant = 1'b0;
    if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req1_valid && req0_valid) begin
`ifdef ALU_ARBITER_RR_EN
      grant = ~last_grant;
`else
      grant = 1'b0;
`endif
    end
  end

  // armed stays low for the first edge after reset release, so nothing is accepted there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      armed <= 1'b0;
      op_q  <= OP_ADD;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      r_q   <= '0;
`ifdef ALU_ARBITER_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (accept) begin
        op_q <= grant ? op_e'(req1_op) : op_e'(req0_op);
        a_q  <= grant ? req1_a : req0_a;
        b_q  <= grant ? req1_b : req0_b;
        id_q <= grant;
`ifdef ALU_ARBITER_RR_EN
        last_grant <= grant;
`endif
      end
      if (state == EXEC) begin
        r_q <= alu_r;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && armed && req0_valid && !grant;
    req1_ready = (state == IDLE) && armed && req1_valid && grant;
    accept     = req0_ready || req1_ready;
    rsp_valid  = (state == RESP);
    busy       = (state != IDLE);
    rsp_r      = r_q;
    rsp_id     = id_q;
  end

endmodule
